led_blinker_multi: RTL and testbench

//  Parametrised multi-channel LED driver; successor of the single-LED 1 Hz toggler.

---
 rtl/led_blinker_multi_pkg.sv | 12 +
 rtl/led_blinker_multi_channel.sv | 82 ++++++++
 rtl/led_blinker_multi.sv | 63 ++++++
 tb/tb_led_blinker_multi.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_blinker_multi_pkg.sv
// Shared types for the multi-channel LED blinker.
// Defines the per-channel mode encoding.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_ONESHOT = 2'd3
   } mode_e;

endpackage

// File: rtl/led_blinker_multi_channel.sv
// One LED channel: mode/period registers, tick counter, led and done.
// Ports: clk, reset, tick, wr_en/wr_mode/wr_period in; led, done out.
module led_channel
   import led_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             wr_en,
   input  mode_e            wr_mode,
   input  logic [CNT_W-1:0] wr_period,
   output logic             led,
   output logic             done
);

   mode_e            mode_q;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] last;

   // A period of 0 behaves as 1, so the terminal count is P-1.
   assign last = (period_q == '0) ? '0 : period_q - 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q   <= MODE_OFF;
         period_q <= '0;
         cnt_q    <= '0;
         led      <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (wr_en) begin
            // A write always wins over a coincident tick.
            mode_q   <= wr_mode;
            period_q <= wr_period;
            cnt_q    <= '0;
            led      <= (wr_mode == MODE_ON) || (wr_mode == MODE_ONESHOT);
         end else begin
            unique case (mode_q)
               MODE_OFF: begin
                  led   <= 1'b0;
                  cnt_q <= '0;
               end
               MODE_ON: begin
                  led   <= 1'b1;
                  cnt_q <= '0;
               end
               MODE_BLINK: begin
                  if (tick) begin
                     if (cnt_q == last) begin
                        led   <= ~led;
                        cnt_q <= '0;
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end
               end
               MODE_ONESHOT: begin
                  if (tick) begin
                     if (cnt_q == last) begin
                        led    <= 1'b0;
                        done   <= 1'b1;
                        mode_q <= MODE_OFF;
                        cnt_q  <= '0;
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end
               end
               default: begin
                  led   <= 1'b0;
                  cnt_q <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/led_blinker_multi.sv
// Multi-channel LED driver with prescaled tick and valid/ready config port.
// Ports: clk, reset, cfg_* write port, cfg_err, tick, led[], done[].
module led_blinker_multi
   import led_pkg::*;
#(
   parameter int NUM_LEDS = 4,
   parameter int TICK_DIV = 12000000,
   parameter int CNT_W    = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [$clog2(NUM_LEDS):0] cfg_ch,
   input  mode_e                     cfg_mode,
   input  logic [CNT_W-1:0]          cfg_period,
   output logic                      cfg_err,
   output logic                      tick,
   output logic [NUM_LEDS-1:0]       led,
   output logic [NUM_LEDS-1:0]       done
);

   localparam int CH_W = $clog2(NUM_LEDS) + 1;
   localparam int PW   = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc_q;
   logic          accept;
   logic          ch_ok;

   assign accept = cfg_valid & cfg_ready;
   assign ch_ok  = (int'(cfg_ch) < NUM_LEDS);

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q   <= '0;
         tick      <= 1'b0;
         cfg_ready <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         presc_q   <= (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
         tick      <= (presc_q == PRE_LAST);
         cfg_ready <= 1'b1;
         cfg_err   <= accept & ~ch_ok;
      end
   end

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      led_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .tick      (tick),
         .wr_en     (accept && (cfg_ch == CH_W'(i))),
         .wr_mode   (cfg_mode),
         .wr_period (cfg_period),
         .led       (led[i]),
         .done      (done[i])
      );
   end

endmodule

// File: tb/tb_led_blinker_multi.sv
// Scoreboard bench for led_blinker_multi (TICK_DIV=4, NUM_LEDS=4).
// Stimulus queues expected values; a negedge monitor checks them.
module tb_led_blinker_multi;
   import led_pkg::*;

   localparam int NL = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [2:0]    cfg_ch;
   mode_e         cfg_mode;
   logic [7:0]    cfg_period;
   logic          cfg_err;
   logic          tick;
   logic [NL-1:0] led;
   logic [NL-1:0] done;

   led_blinker_multi #(
      .NUM_LEDS (NL),
      .TICK_DIV (4),
      .CNT_W    (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .cfg_err    (cfg_err),
      .tick       (tick),
      .led        (led),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      int          kind;
      logic [15:0] val;
   } chk_t;

   chk_t lvl_q[$];
   chk_t done_q[$];
   chk_t err_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // kind: 0 led, 1 tick, 2 cfg_ready
   task automatic exp_lvl(input int c, input int k, input logic [15:0] v);
      lvl_q.push_back('{cyc: c, kind: k, val: v});
   endtask

   task automatic check(input string nm, input int c,
                        input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cyc >= 3) begin
         for (int i = lvl_q.size() - 1; i >= 0; i--) begin
            if (lvl_q[i].cyc == cyc) begin
               case (lvl_q[i].kind)
                  0: check("led", cyc, {12'b0, led}, lvl_q[i].val);
                  1: check("tick", cyc, {15'b0, tick}, lvl_q[i].val);
                  default: check("cfg_ready", cyc, {15'b0, cfg_ready},
                                 lvl_q[i].val);
               endcase
               lvl_q.delete(i);
            end
         end
         if (done !== '0) begin
            int hit = -1;
            for (int i = 0; i < done_q.size(); i++)
               if (done_q[i].cyc == cyc) hit = i;
            if (hit < 0) begin
               check("done_unexpected", cyc, {12'b0, done}, 16'h0);
            end else begin
               check("done", cyc, {12'b0, done}, done_q[hit].val);
               done_q.delete(hit);
            end
         end
         if (cfg_err !== 1'b0) begin
            int hit = -1;
            for (int i = 0; i < err_q.size(); i++)
               if (err_q[i].cyc == cyc) hit = i;
            if (hit < 0) begin
               check("err_unexpected", cyc, {15'b0, cfg_err}, 16'h0);
            end else begin
               check("cfg_err", cyc, {15'b0, cfg_err}, err_q[hit].val);
               err_q.delete(hit);
            end
         end
      end
   end

   task automatic at_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write(input int ch, input mode_e m, input int p);
      cfg_valid  = 1'b1;
      cfg_ch     = 3'(ch);
      cfg_mode   = m;
      cfg_period = 8'(p);
      @(posedge clk);
      #1;
      cfg_valid  = 1'b0;
   endtask

   initial begin
      #20000;
      n_bad++;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      cfg_valid  = 1'b0;
      cfg_ch     = '0;
      cfg_mode   = MODE_OFF;
      cfg_period = '0;

      // reset state, ready rise, tick cadence
      exp_lvl(3, 0, 16'h0);
      exp_lvl(3, 2, 16'h0);
      exp_lvl(3, 1, 16'h0);
      exp_lvl(4, 2, 16'h1);
      exp_lvl(6, 1, 16'h0);
      exp_lvl(7, 1, 16'h1);
      exp_lvl(8, 1, 16'h0);
      exp_lvl(11, 1, 16'h1);
      at_cyc(3);
      reset = 1'b0;

      // ch1 blink P=2, accepted at edge 10
      at_cyc(9);
      exp_lvl(10, 0, 16'h0);
      exp_lvl(15, 0, 16'h0);
      exp_lvl(16, 0, 16'h2);
      write(1, MODE_BLINK, 2);

      // ch0 oneshot P=3, accepted at edge 18
      at_cyc(17);
      exp_lvl(18, 0, 16'h3);
      exp_lvl(23, 0, 16'h3);
      exp_lvl(24, 0, 16'h1);
      exp_lvl(27, 0, 16'h1);
      exp_lvl(28, 0, 16'h0);
      done_q.push_back('{cyc: 28, kind: 3, val: 16'h1});
      write(0, MODE_ONESHOT, 3);

      // ch2 on then off; ch3 blink with period 0
      at_cyc(29);
      exp_lvl(30, 0, 16'h4);
      exp_lvl(31, 0, 16'h0);
      exp_lvl(32, 0, 16'h2);
      exp_lvl(35, 0, 16'h2);
      exp_lvl(36, 0, 16'hA);
      exp_lvl(40, 0, 16'h0);
      exp_lvl(44, 0, 16'h8);
      write(2, MODE_ON, 0);
      write(2, MODE_OFF, 0);
      at_cyc(33);
      write(3, MODE_BLINK, 0);

      // out-of-range channel
      at_cyc(45);
      exp_lvl(46, 0, 16'h8);
      exp_lvl(48, 0, 16'h2);
      err_q.push_back('{cyc: 46, kind: 4, val: 16'h1});
      write(5, MODE_ON, 7);

      // write on ch3 coincident with a tick edge (52)
      at_cyc(51);
      exp_lvl(52, 0, 16'h2);
      exp_lvl(56, 0, 16'h8);
      write(3, MODE_BLINK, 1);

      // reset mid-oneshot and mid-blink
      at_cyc(57);
      exp_lvl(58, 0, 16'h9);
      exp_lvl(60, 0, 16'h1);
      write(0, MODE_ONESHOT, 3);
      at_cyc(61);
      exp_lvl(62, 0, 16'h0);
      exp_lvl(62, 2, 16'h0);
      exp_lvl(62, 1, 16'h0);
      exp_lvl(63, 2, 16'h1);
      exp_lvl(65, 1, 16'h0);
      exp_lvl(66, 1, 16'h1);
      exp_lvl(70, 0, 16'h0);
      exp_lvl(79, 0, 16'h0);
      reset = 1'b1;
      at_cyc(62);
      reset = 1'b0;

      at_cyc(80);
      foreach (lvl_q[i])
         check("lvl_missed", lvl_q[i].cyc, 16'hDEAD, lvl_q[i].val);
      foreach (done_q[i])
         check("done_missing", done_q[i].cyc, 16'h0, done_q[i].val);
      foreach (err_q[i])
         check("err_missing", err_q[i].cyc, 16'h0, err_q[i].val);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
